// File: rtl/lm70_pkg.sv
// Shared types and constants for the LM70 sensor emulator.
// Frame helper builds the 16-bit LM70 read word from whole-degree Celsius.
package lm70_pkg;

  localparam int LM70_FRAME_W = 16;
  localparam int LM70_CNT_W   = $clog2(LM70_FRAME_W + 1);

  localparam logic [LM70_FRAME_W-1:0] LM70_SHUTDOWN_CODE = 16'h00FF;
  localparam logic [LM70_FRAME_W-1:0] LM70_RUN_CODE      = 16'h0000;
  localparam logic [LM70_FRAME_W-1:0] LM70_ID_WORD       = 16'h800F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } lm70_state_t;

  // 11-bit two's complement in 0.25 C steps, then five trailing ones
  function automatic logic [LM70_FRAME_W-1:0] lm70_temp_frame(input logic [7:0] t);
    return {t[7], t, 2'b00, 5'b11111};
  endfunction

endpackage

// File: rtl/lm70_sensor_emu_sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous input, with level and one-clk rise/fall pulses.
// STAGES must be at least 2; pulses appear STAGES clks after the raw edge.
module sync_edge_det #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/lm70_sensor_emu.sv
// LM70 SPI responder: serves a 16-bit temperature/ID read frame, then accepts a
// 16-bit config write that enters or leaves shutdown. cs_n rising always aborts to IDLE.
module lm70_sensor_emu
  import lm70_pkg::*;
#(
  parameter int                      SYNC_STAGES   = 2,
  parameter logic [LM70_FRAME_W-1:0] SHUTDOWN_CODE = LM70_SHUTDOWN_CODE,
  parameter logic [LM70_FRAME_W-1:0] RUN_CODE      = LM70_RUN_CODE,
  parameter logic [LM70_FRAME_W-1:0] ID_WORD       = LM70_ID_WORD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs_n,
  input  logic       sck,
  input  logic       sio_in,
  output logic       sio_out,
  output logic       sio_oe,
  input  logic [7:0] temp_c,
  output logic       shutdown,
  output logic       frame_done
);

  localparam logic [LM70_CNT_W-1:0] LAST_BIT = LM70_CNT_W'(LM70_FRAME_W - 1);

  logic cs_lvl_unused, cs_rise, cs_fall;
  logic sck_lvl_unused, sck_rise, sck_fall;
  logic sio_sync, sio_rise_unused, sio_fall_unused;

  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst(rst), .din(cs_n),
    .level(cs_lvl_unused), .rise(cs_rise), .fall(cs_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
    .clk(clk), .rst(rst), .din(sck),
    .level(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall)
  );

  sync_edge_det #(.STAGES(2), .RESET_VAL(1'b0)) u_sio_sync (
    .clk(clk), .rst(rst), .din(sio_in),
    .level(sio_sync), .rise(sio_rise_unused), .fall(sio_fall_unused)
  );

  lm70_state_t             state_q, state_d;
  logic [LM70_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [LM70_FRAME_W-1:0] tx_sr_q, tx_sr_d;
  logic [LM70_FRAME_W-1:0] rx_sr_q, rx_sr_d;
  logic                    sio_out_q, sio_out_d;
  logic                    sio_oe_q, sio_oe_d;
  logic                    shutdown_q, shutdown_d;
  logic                    frame_done_q, frame_done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      tx_sr_q      <= '0;
      rx_sr_q      <= '0;
      sio_out_q    <= 1'b0;
      sio_oe_q     <= 1'b0;
      shutdown_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      tx_sr_q      <= tx_sr_d;
      rx_sr_q      <= rx_sr_d;
      sio_out_q    <= sio_out_d;
      sio_oe_q     <= sio_oe_d;
      shutdown_q   <= shutdown_d;
      frame_done_q <= frame_done_d;
    end
  end

  // cs_rise takes priority over everything, including a coincident sck edge
  always_comb begin
    state_d = state_q;
    if (cs_rise) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (cs_fall) state_d = READ;
        READ:    if (sck_rise && bit_cnt_q == LAST_BIT) state_d = WRITE;
        WRITE:   if (sck_rise && bit_cnt_q == LAST_BIT) state_d = DONE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    tx_sr_d      = tx_sr_q;
    rx_sr_d      = rx_sr_q;
    sio_out_d    = sio_out_q;
    sio_oe_d     = sio_oe_q;
    shutdown_d   = shutdown_q;
    frame_done_d = 1'b0;
    if (cs_rise) begin
      sio_oe_d  = 1'b0;
      bit_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cs_fall) begin
            tx_sr_d   = shutdown_q ? ID_WORD : lm70_temp_frame(temp_c);
            sio_out_d = tx_sr_d[LM70_FRAME_W-1];
            sio_oe_d  = 1'b1;
            bit_cnt_d = '0;
          end
        end
        READ: begin
          if (sck_rise) begin
            if (bit_cnt_q == LAST_BIT) begin
              sio_oe_d  = 1'b0;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else if (sck_fall) begin
            tx_sr_d   = tx_sr_q << 1;
            sio_out_d = tx_sr_q[LM70_FRAME_W-2];
          end
        end
        WRITE: begin
          if (sck_rise) begin
            rx_sr_d   = {rx_sr_q[LM70_FRAME_W-2:0], sio_sync};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
              if (rx_sr_d == SHUTDOWN_CODE)  shutdown_d = 1'b1;
              else if (rx_sr_d == RUN_CODE)  shutdown_d = 1'b0;
              frame_done_d = 1'b1;
              bit_cnt_d    = '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sio_out    = sio_out_q;
  assign sio_oe     = sio_oe_q;
  assign shutdown   = shutdown_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lm70_sensor_emu.sv
// Drives an SPI mode-0 master at clk/8 against the LM70 emulator and compares
// read words, sio_oe, shutdown and frame_done with a transaction-level model.
module tb_lm70_sensor_emu;

  logic       clk = 1'b0;
  logic       rst, cs_n, sck, sio_in;
  logic       sio_out, sio_oe, shutdown, frame_done;
  logic [7:0] temp_c;

  int total = 0;
  int bad   = 0;
  int fd_cnt = 0;
  bit model_sd = 1'b0;

  lm70_sensor_emu dut (
    .clk(clk), .rst(rst), .cs_n(cs_n), .sck(sck), .sio_in(sio_in),
    .sio_out(sio_out), .sio_oe(sio_oe), .temp_c(temp_c),
    .shutdown(shutdown), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: degrees scaled to quarter-degree units, 11-bit wrap, five ones appended
  function automatic logic [15:0] model_read(input bit sd, input logic [7:0] t);
    int q;
    if (sd) return 16'h800F;
    q = $signed(t) * 4;
    return 16'(((q & 'h7FF) << 5) | 31);
  endfunction

  function automatic logic [15:0] first_bits_mask(input int n);
    logic [15:0] m;
    m = 16'hFFFF;
    if (n < 16) m = m << (16 - n);
    return m;
  endfunction

  // One CS-framed transfer of nbits SCK cycles; bits 16..31 carry the write word
  task automatic xfer(input int nbits, input logic [15:0] wr, input bit do_mid,
                      input logic [7:0] mid_temp, output logic [15:0] rd);
    rd = '0;
    sio_in = 1'b0;
    cs_n = 1'b0;
    #80;
    check("oe_after_cs_fall", {31'd0, sio_oe}, 32'd1);
    for (int i = 0; i < nbits; i++) begin
      if (i >= 16) sio_in = wr[31-i];
      if (do_mid && i == 8) temp_c = mid_temp;
      #40;
      sck = 1'b1;
      if (i < 16) rd[15-i] = sio_out;
      if (i == 15) begin
        #35;
        check("oe_off_after_16", {31'd0, sio_oe}, 32'd0);
        #5;
      end else begin
        #40;
      end
      sck = 1'b0;
    end
    #40;
    cs_n = 1'b1;
    #80;
  endtask

  task automatic run_and_check(input string tag, input int nbits, input logic [15:0] wr,
                               input logic [7:0] t, input bit do_mid, input logic [7:0] mid_t);
    logic [15:0] rd, exp, m;
    int fd_before;
    temp_c = t;
    exp = model_read(model_sd, t);
    m = first_bits_mask(nbits);
    fd_before = fd_cnt;
    xfer(nbits, wr, do_mid, mid_t, rd);
    if (nbits == 32) begin
      if (wr == 16'h00FF) model_sd = 1'b1;
      else if (wr == 16'h0000) model_sd = 1'b0;
    end
    check({tag, "_rd"}, {16'd0, rd & m}, {16'd0, exp & m});
    check({tag, "_fd"}, fd_cnt - fd_before, (nbits == 32) ? 1 : 0);
    check({tag, "_sd"}, {31'd0, shutdown}, {31'd0, model_sd});
    check({tag, "_oe_idle"}, {31'd0, sio_oe}, 32'd0);
  endtask

  initial begin
    logic [15:0] wr;
    int n;
    rst = 1'b1; cs_n = 1'b1; sck = 1'b0; sio_in = 1'b0; temp_c = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sio_out", {31'd0, sio_out}, 32'd0);
    check("rst_sio_oe", {31'd0, sio_oe}, 32'd0);
    check("rst_shutdown", {31'd0, shutdown}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    rst = 1'b0;
    #1;
    #40;

    run_and_check("t25", 16, 16'h0000, 8'd25, 1'b0, 8'd0);
    check("t25_const", {16'd0, model_read(1'b0, 8'd25)}, 32'h0C9F);
    run_and_check("tneg10", 16, 16'h0000, 8'hF6, 1'b1, 8'd50);
    run_and_check("wr_sd", 32, 16'h00FF, 8'd30, 1'b0, 8'd0);
    run_and_check("rd_id", 16, 16'h0000, 8'd30, 1'b0, 8'd0);
    run_and_check("wr_run", 32, 16'h0000, 8'd30, 1'b0, 8'd0);
    run_and_check("rd_back", 16, 16'h0000, 8'd30, 1'b0, 8'd0);
    run_and_check("abort8", 8, 16'h0000, 8'd77, 1'b0, 8'd0);
    run_and_check("after_abort", 16, 16'h0000, 8'd77, 1'b0, 8'd0);
    run_and_check("abort24", 24, 16'h00FF, 8'd12, 1'b0, 8'd0);

    // reset in the middle of a read, with shutdown previously set
    run_and_check("pre_rst_sd", 32, 16'h00FF, 8'd5, 1'b0, 8'd0);
    cs_n = 1'b0;
    #80;
    for (int i = 0; i < 3; i++) begin
      #40 sck = 1'b1;
      #40 sck = 1'b0;
    end
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    model_sd = 1'b0;
    check("midrst_oe", {31'd0, sio_oe}, 32'd0);
    check("midrst_sd", {31'd0, shutdown}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    cs_n = 1'b1;
    #1;
    #80;
    run_and_check("post_rst", 16, 16'h0000, 8'd100, 1'b0, 8'd0);

    for (int k = 0; k < 20; k++) begin
      n = 8 * (1 + $urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: wr = 16'h00FF;
        1: wr = 16'h0000;
        default: wr = 16'($urandom);
      endcase
      run_and_check("rand", n, wr, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                    8'($urandom_range(0, 255)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
